// File: rtl/iter_divider_pkg.sv
// Shared MDU-family definitions: default operand width, divider FSM encoding
// and the quotient returned for a zero divisor.
package iter_divider_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DEF_WIDTH-1:0] DIV0_Q = '1;

endpackage

// File: rtl/iter_divider_if.sv
// Request/result bundle between an initiator and the iterative divider.
interface iter_divider_if #(parameter int WIDTH = iter_divider_pkg::DEF_WIDTH) ();

    // Handshake: a request is taken on any rising edge where start=1 and busy=0;
    // operands and is_signed are sampled on that edge only. busy stays high from
    // the cycle after acceptance through the completion cycle. over is a
    // one-cycle pulse marking q/r valid; there is no backpressure, and q/r hold
    // until the next accepted operation completes.
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             over;

    modport master (
        output start, is_signed, dividend, divisor,
        input  q, r, busy, over
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output q, r, busy, over
    );

endinterface

// File: rtl/iter_divider_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step #(parameter int WIDTH = iter_divider_pkg::DEF_WIDTH) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor holds, so the shifted value always fits in WIDTH+1 bits.
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned divider: one restoring step per cycle, WIDTH steps,
// then a single DONE cycle that pulses over with registered q/r.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    iter_divider_if.slave bus,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             busy_r;
    logic             over_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    assign a_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign b_mag = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // quo starts as the dividend magnitude; its MSB feeds each step while
    // quotient bits shift in from the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (quo[WIDTH-1]),
        .divisor (dvs_mag),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    assign quo_next  = {quo[WIDTH-2:0], step_qbit};
    assign last_step = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            q_r      <= '0;
            r_r      <= '0;
            busy_r   <= 1'b0;
            over_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_RUN;
                        busy_r   <= 1'b1;
                        count    <= '0;
                        rem      <= '0;
                        quo      <= a_mag;
                        dvs_mag  <= b_mag;
                        neg_q    <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        neg_r    <= bus.is_signed & bus.dividend[WIDTH-1];
                        div_zero <= (bus.divisor == '0);
                    end
                end
                ST_RUN: begin
                    rem   <= step_rem;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (last_step) begin
                        state  <= ST_DONE;
                        over_r <= 1'b1;
                        // Zero divisor: remainder already equals the dividend after
                        // sign restore; only the quotient is forced.
                        q_r    <= div_zero ? WIDTH'(DIV0_Q) : (neg_q ? -quo_next : quo_next);
                        r_r    <= neg_r ? -step_rem : step_rem;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    over_r <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    over_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q     = q_r;
    assign bus.r     = r_r;
    assign bus.busy  = busy_r;
    assign bus.over  = over_r;
    assign dbg_state = state;

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high; also serves as the initiator's abort.
REQ-004 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port q  output  WIDTH  registered quotient.
REQ-009 SHALL have port r  output  WIDTH  registered remainder.
REQ-010 SHALL have port busy  output  1  high while an operation is in flight, including the completion cycle.
REQ-011 SHALL have port over  output  1  one-cycle pulse marking q/r valid.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; busy=1 in RUN and DONE, over=1 only in DONE.
REQ-013 SHALL, in IDLE with start=1 at edge k, latch operands, mode and magnitudes, clear iteration counter, enter RUN.
REQ-014 SHALL perform one radix-2 restoring step per RUN cycle (shift partial remainder left, shift in next dividend bit, trial-subtract divisor magnitude, keep the result if non-negative, set the quotient bit accordingly).
REQ-015 SHALL leave RUN after exactly WIDTH steps (cycles k+1..k+32) and be in DONE during cycle k+33; over asserts exactly that cycle, then IDLE.
REQ-016 SHALL load q/r only on the transition into DONE and hold them unchanged until the next accepted operation completes.
REQ-017 SHALL ignore start in RUN and DONE; neither operands nor the counter change.
REQ-018 SHALL, in signed mode, divide magnitudes, negate quotient when operand signs differ, give remainder the dividend's sign (truncate toward zero).
REQ-019 SHALL, for signed 0x80000000 / 0xFFFFFFFF, return q=0x80000000, r=0 with normal latency.
REQ-020 SHALL, for divisor=0 (either mode), return q=0xFFFFFFFF, r=dividend with normal latency; no exception signal.
REQ-021 SHALL, with start held high continuously, accept a new operation in the IDLE cycle after DONE (back-to-back spacing 34 cycles).

Reset
REQ-022 SHALL, while reset=1 at an edge, force state IDLE, busy=0, over=0, q=0, r=0, counter and datapath registers 0.
REQ-023 SHALL abort any operation in RUN or DONE on reset with no over pulse; reset has priority over start at the same edge.
REQ-024 SHALL accept start on the first edge where reset=0 and state is IDLE.

Structure
REQ-025 SHALL take state encoding, WIDTH default and the divide-by-zero quotient constant from the shared package used by the MDU family.
REQ-026 SHALL place the single restoring step (partial remainder, divisor in; next remainder, quotient bit out) in sub-module div_step, instantiated once.
REQ-027 SHALL contain no combinational path from inputs to any output; all outputs registered.

Verification
REQ-028 SHALL cover: unsigned 100 / 7, start at edge 0 -> busy cycles 1-33, over only cycle 33, q=14, r=2.
REQ-029 SHALL cover: signed -7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7 / -2 -> q=0xFFFFFFFD, r=1.
REQ-030 SHALL cover: 0x80000000 / 0xFFFFFFFF signed -> q=0x80000000, r=0; unsigned -> q=0, r=0x80000000.
REQ-031 SHALL cover: 5 / 0 both modes -> q=0xFFFFFFFF, r=5, over at cycle 33.
REQ-032 SHALL cover: reset in RUN cycle 10 -> next cycle busy=0, over=0, q=r=0; no over pulse afterward; new start completes normally.
REQ-033 SHALL cover: start re-pulsed with new operands in RUN cycle 5 -> ignored; original result delivered at cycle 33.
